// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: the producer/consumer side uses
// master, the ALU itself uses slave.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides. Define ALU_PIPE_FLAGS_EN
// to build the {overflow, carry, negative, zero} flag logic; otherwise flags is 0.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int S = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_illegal;

  logic             s2_ready;
  logic             s1_load;
  logic             s1_move;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [S-1:0]     shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;

  // in_ready looks through an empty or draining S2 straight to out_ready
  assign s2_ready     = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_ready;
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign s1_move      = s1_valid && s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
      s1_op    <= bus.op;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  assign sum   = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff  = {1'b0, s1_a} - {1'b0, s1_b};
  assign shamt = s1_b[S-1:0];

  // diff[WIDTH] is the unsigned borrow, which is exactly the SLTU answer
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (s1_op)
      OP_ADD:  alu_result = sum[WIDTH-1:0];
      OP_SUB:  alu_result = diff[WIDTH-1:0];
      OP_AND:  alu_result = s1_a & s1_b;
      OP_OR:   alu_result = s1_a | s1_b;
      OP_XOR:  alu_result = s1_a ^ s1_b;
      OP_SHL:  alu_result = s1_a << shamt;
      OP_SHR:  alu_result = s1_a >> shamt;
      OP_SRA:  alu_result = $signed(s1_a) >>> shamt;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_illegal <= 1'b0;
    end else if (s1_move) begin
      s2_valid   <= 1'b1;
      s2_result  <= alu_result;
      s2_illegal <= alu_illegal;
    end else if (bus.out_ready) begin
      s2_valid   <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.illegal   = s2_illegal;

`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] alu_flags;
  logic [3:0] s2_flags;

  always_comb begin
    alu_flags = 4'b0000;
    if (!alu_illegal) begin
      case (s1_op)
        OP_ADD: begin
          alu_flags[3] = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != s1_a[WIDTH-1]);
          alu_flags[2] = sum[WIDTH];
        end
        OP_SUB: begin
          alu_flags[3] = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != s1_a[WIDTH-1]);
          alu_flags[2] = diff[WIDTH];
        end
        default: ;
      endcase
      alu_flags[1] = alu_result[WIDTH-1];
      alu_flags[0] = (alu_result == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_flags <= 4'b0000;
    end else if (s1_move) begin
      s2_flags <= alu_flags;
    end
  end

  assign bus.flags = s2_flags;
`else
  logic unused_carry;
  assign unused_carry = sum[WIDTH];
  assign bus.flags    = 4'b0000;
`endif

endmodule
